// File: rtl/polaris_ifetch.sv
// polaris_ifetch: instruction fetch unit with a DEPTH-entry prefetch queue.
// Issues word fetches at fpc, queues {pc, insn} pairs and hands them to the
// consumer in order. A redirect flushes the queue and restarts fetching.
// Optional macro IFETCH_MISALIGN_TRAP_EN: a misaligned redirect raises fault_o
// and parks the unit in JAM until reset. Without it the target is word-aligned.
module polaris_ifetch #(
    parameter int unsigned   AW           = 64,
    parameter int unsigned   DEPTH        = 4,
    parameter logic [AW-1:0] RESET_VECTOR = 64'hFFFF_FFFF_FFFF_FF00
) (
    input  logic          clk_i,
    input  logic          reset_i,
    output logic          istb_o,
    output logic [AW-1:0] iadr_o,
    output logic [1:0]    isiz_o,
    input  logic          iack_i,
    input  logic [31:0]   idat_i,
    output logic          insn_valid_o,
    output logic [31:0]   insn_o,
    output logic [AW-1:0] insn_pc_o,
    input  logic          insn_ready_i,
    input  logic          redir_i,
    input  logic [AW-1:0] redir_pc_i,
    output logic          fault_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_FETCH,
        S_FLUSH
`ifdef IFETCH_MISALIGN_TRAP_EN
        , S_JAM
`endif
    } state_t;

    state_t        state;
    logic [AW-1:0] fpc;
    logic [CW-1:0] count;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [31:0]   q_insn [DEPTH];
    logic [AW-1:0] q_pc   [DEPTH];

    logic          jammed;
    logic          push;
    logic          pop;
    logic [AW-1:0] redir_target;
    logic          fault_q;

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign jammed       = (state == S_JAM);
    assign redir_target = redir_pc_i;
`else
    assign jammed       = 1'b0;
    assign redir_target = redir_pc_i & ~(AW'(3));
`endif

    assign istb_o       = (state == S_FETCH) && (count < FULL);
    assign iadr_o       = istb_o ? fpc : '0;
    assign isiz_o       = istb_o ? 2'b10 : 2'b00;
    assign insn_valid_o = (count != '0);
    assign insn_o       = q_insn[rptr];
    assign insn_pc_o    = q_pc[rptr];
    assign push         = istb_o && iack_i;
    assign pop          = insn_valid_o && insn_ready_i;
    assign fault_o      = fault_q;

    // Fetch state, fetch PC, queue storage and occupancy; redirect wins over push/pop.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= S_FLUSH;
            fpc     <= RESET_VECTOR;
            count   <= '0;
            wptr    <= '0;
            rptr    <= '0;
            fault_q <= 1'b0;
        end else if (!jammed) begin
            if (redir_i) begin
                state <= S_FLUSH;
                fpc   <= redir_target;
                count <= '0;
                wptr  <= '0;
                rptr  <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
                if (redir_pc_i[1:0] != 2'b00) begin
                    state   <= S_JAM;
                    fault_q <= 1'b1;
                end
`endif
            end else begin
                state <= S_FETCH;
                if (push) begin
                    q_insn[wptr] <= idat_i;
                    q_pc[wptr]   <= fpc;
                    wptr         <= wptr + 1'b1;
                    fpc          <= fpc + AW'(4);
                end
                if (pop) begin
                    rptr <= rptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_polaris_ifetch.sv
// Self-checking bench for polaris_ifetch: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_polaris_ifetch;

    localparam int unsigned   AW    = 64;
    localparam int unsigned   DEPTH = 4;
    localparam logic [63:0]   RV    = 64'hFFFF_FFFF_FFFF_FF00;

    logic          clk_i;
    logic          reset_i;
    logic          istb_o;
    logic [AW-1:0] iadr_o;
    logic [1:0]    isiz_o;
    logic          iack_i;
    logic [31:0]   idat_i;
    logic          insn_valid_o;
    logic [31:0]   insn_o;
    logic [AW-1:0] insn_pc_o;
    logic          insn_ready_i;
    logic          redir_i;
    logic [AW-1:0] redir_pc_i;
    logic          fault_o;

    polaris_ifetch #(
        .AW           (AW),
        .DEPTH        (DEPTH),
        .RESET_VECTOR (RV)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .istb_o       (istb_o),
        .iadr_o       (iadr_o),
        .isiz_o       (isiz_o),
        .iack_i       (iack_i),
        .idat_i       (idat_i),
        .insn_valid_o (insn_valid_o),
        .insn_o       (insn_o),
        .insn_pc_o    (insn_pc_o),
        .insn_ready_i (insn_ready_i),
        .redir_i      (redir_i),
        .redir_pc_i   (redir_pc_i),
        .fault_o      (fault_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model: what the fetch unit should be doing, in plain terms.
    logic [63:0] m_fpc;
    bit          m_flush;
    bit          m_jam;
    bit          m_fault;
    logic [63:0] m_qpc[$];
    logic [31:0] m_qins[$];

`ifdef IFETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit exp_istb();
        return !m_flush && !m_jam && (m_qpc.size() < DEPTH);
    endfunction

    task automatic check_all();
        bit s;
        s = exp_istb();
        check("istb", 64'(istb_o), 64'(s));
        check("iadr", iadr_o, s ? m_fpc : 64'd0);
        check("isiz", 64'(isiz_o), s ? 64'd2 : 64'd0);
        check("valid", 64'(insn_valid_o), 64'(m_qpc.size() > 0));
        if (m_qpc.size() > 0) begin
            check("insn", 64'(insn_o), 64'(m_qins[0]));
            check("insn_pc", insn_pc_o, m_qpc[0]);
        end
        check("fault", 64'(fault_o), 64'(m_fault));
    endtask

    // Apply the inputs present at a clock edge to the model.
    task automatic model_edge();
        bit s;
        bit do_pop;
        s = exp_istb();
        if (reset_i) begin
            m_fpc = RV; m_flush = 1; m_jam = 0; m_fault = 0;
            m_qpc.delete(); m_qins.delete();
        end else if (m_jam) begin
            // parked until reset
        end else if (redir_i) begin
            m_qpc.delete(); m_qins.delete();
            m_flush = 1;
            if (TRAP && redir_pc_i[1:0] != 2'b00) begin
                m_jam = 1; m_fault = 1; m_fpc = redir_pc_i;
            end else begin
                m_fpc = {redir_pc_i[63:2], 2'b00};
            end
        end else begin
            do_pop = (m_qpc.size() > 0) && insn_ready_i;
            if (do_pop) begin
                void'(m_qpc.pop_front()); void'(m_qins.pop_front());
            end
            if (s && iack_i) begin
                m_qpc.push_back(m_fpc); m_qins.push_back(idat_i);
                m_fpc = m_fpc + 64'd4;
            end
            m_flush = 0;
        end
    endtask

    // One clock: check current outputs, advance across the edge, settle.
    task automatic cycle();
        check_all();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit rst, input bit rd, input logic [63:0] rpc,
                         input bit ack, input bit rdy);
        reset_i = rst; redir_i = rd; redir_pc_i = rpc;
        iack_i = ack; insn_ready_i = rdy; idat_i = $urandom;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0);
        @(posedge clk_i);
        model_edge();
        #1;
        cycle();

        // Straight-line fetch from the reset vector.
        drive(0, 0, 0, 1, 1);
        check("rst_istb", 64'(istb_o), 64'd0);
        check("rst_iadr", iadr_o, 64'd0);
        cycle();
        check("first_iadr", iadr_o, RV);
        drive(0, 0, 0, 1, 1);
        cycle();
        check("second_iadr", iadr_o, RV + 64'd4);
        check("head_pc0", insn_pc_o, RV);
        drive(0, 0, 0, 1, 1);
        cycle();
        check("third_iadr", iadr_o, RV + 64'd8);

        // Fill with no consumer, then release one slot.
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 1, 0);
            cycle();
        end
        check("full_istb", 64'(istb_o), 64'd0);
        drive(0, 0, 0, 0, 1);
        cycle();
        check("after_pop_istb", 64'(istb_o), 64'd1);

        // Redirect colliding with an ack and a pop.
        drive(0, 1, 64'h1000, 1, 1);
        cycle();
        check("redir_valid", 64'(insn_valid_o), 64'd0);
        check("redir_istb", 64'(istb_o), 64'd0);
        drive(0, 0, 0, 0, 1);
        cycle();
        check("redir_iadr", iadr_o, 64'h1000);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 1);
            cycle();
        end

        // Address wrap at the top of the space.
        drive(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1);
        cycle();
        drive(0, 0, 0, 1, 1);
        cycle();
        check("wrap_top", iadr_o, 64'hFFFF_FFFF_FFFF_FFFC);
        drive(0, 0, 0, 1, 1);
        cycle();
        check("wrap_zero", iadr_o, 64'd0);

        // Misaligned redirect.
        drive(0, 1, 64'h1002, 1, 1);
        cycle();
        drive(0, 0, 0, 1, 1);
        cycle();
`ifdef IFETCH_MISALIGN_TRAP_EN
        check("jam_fault", 64'(fault_o), 64'd1);
        check("jam_istb", 64'(istb_o), 64'd0);
        drive(0, 1, 64'h2000, 1, 1);
        cycle();
        check("jam_hold", 64'(istb_o), 64'd0);
        drive(1, 0, 0, 0, 0);
        cycle();
`else
        check("misalign_iadr", iadr_o, 64'h1000);
        check("misalign_fault", 64'(fault_o), 64'd0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] rpc;
            rpc = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0;
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, rpc,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6);
            cycle();
        end
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/polaris_ifetch.md
POLARIS_IFETCH -- requirements
Module: polaris_ifetch

Interface
REQ-001 Parameter AW, default 64, width of instruction addresses.
REQ-002 Parameter DEPTH, default 4, prefetch queue entries; power of two, 2..16.
REQ-003 Parameter RESET_VECTOR, default 64'hFFFF_FFFF_FFFF_FF00, first fetch address after reset.
REQ-004 The block SHALL use one clock, clk_i, and a synchronous, active-high reset, reset_i.
REQ-005 Ports, as name, direction, width, meaning:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- istb_o  out  1  fetch request valid
- iadr_o  out  AW  fetch address; 0 when istb_o=0
- isiz_o  out  2  2'b10 (word) when istb_o=1, else 2'b00
- iack_i  in  1  fetch complete; idat_i valid this cycle
- idat_i  in  32  fetched instruction word
- insn_valid_o  out  1  queue head valid
- insn_o  out  32  queue head instruction
- insn_pc_o  out  AW  address of queue head instruction
- insn_ready_i  in  1  consumer accepts head
- redir_i  in  1  redirect/flush request
- redir_pc_i  in  AW  redirect target
- fault_o  out  1  misaligned-redirect fault (see Configuration)

Function
REQ-006 Fetch PC register fpc SHALL hold the next address to fetch; iadr_o=fpc whenever istb_o=1.
REQ-007 istb_o SHALL be 1 when state=FETCH and queue occupancy < DEPTH; address and size SHALL stay stable until iack_i.
REQ-008 On iack_i with istb_o=1 and no redir_i, {fpc, idat_i} SHALL be pushed and fpc SHALL advance by 4, wrapping modulo 2^AW.
REQ-009 iack_i while istb_o=0 SHALL be ignored.
REQ-010 Pushed entry SHALL appear at the head one cycle after iack_i, never combinationally.
REQ-011 Pop SHALL occur when insn_valid_o and insn_ready_i; simultaneous push and pop leaves occupancy unchanged.
REQ-012 Queue SHALL be FIFO ordered; read/write pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
REQ-013 When full, istb_o SHALL be 0; a pop in cycle N permits istb_o=1 in cycle N+1.
REQ-014 States: FETCH, FLUSH, JAM. FETCH issues requests; FLUSH lasts exactly one cycle with istb_o=0, then FETCH; JAM holds istb_o=0 until reset.
REQ-015 redir_i in any state other than JAM SHALL, at the next edge, empty the queue, load fpc<=redir_pc_i, discard any same-cycle iack_i or pop, and enter FLUSH.
REQ-016 redir_i SHALL take priority over push, pop and fullness; an abandoned in-flight request is not re-issued.
REQ-017 insn_valid_o SHALL be 0 in the cycle following a redirect.

Reset
REQ-018 reset_i, sampled at an edge, SHALL set fpc=RESET_VECTOR, occupancy=0, pointers=0, state=FLUSH, fault_o=0; reset overrides redir_i and iack_i.
REQ-019 In the cycle after reset: istb_o=0, insn_valid_o=0, iadr_o=0, isiz_o=2'b00; the first request at RESET_VECTOR follows one cycle later.
REQ-020 Reset asserted mid-request SHALL abandon it; an iack_i in that cycle is discarded.

Configuration
REQ-021 Macro IFETCH_MISALIGN_TRAP_EN: when defined, a redirect with redir_pc_i[1:0]!=0 SHALL flush the queue, set fault_o=1, and enter JAM; fpc is loaded with redir_pc_i unchanged.
REQ-022 Without IFETCH_MISALIGN_TRAP_EN, redir_pc_i[1:0] SHALL be forced to 2'b00, fault_o SHALL be tied 0, and the JAM state SHALL not exist.

Verification
REQ-023 Reset, iack_i tied 1, insn_ready_i=1 -> first iadr_o=FFFF_FFFF_FFFF_FF00 two cycles after reset release, then FF04, FF08; insn_pc_o follows one cycle after each ack.
REQ-024 insn_ready_i=0, DEPTH=4, iack_i=1 -> exactly 4 pushes, then istb_o=0; one pop -> istb_o=1 next cycle at the fifth address.
REQ-025 redir_i=1, redir_pc_i=0x1000, with iack_i=1 and a pending pop the same cycle -> next cycle insn_valid_o=0 and istb_o=0; following cycle iadr_o=0x1000; no stale entry is ever delivered.
REQ-026 fpc=FFFF_FFFF_FFFF_FFFC, acked -> next iadr_o=0 (wrap).
REQ-027 With IFETCH_MISALIGN_TRAP_EN, redirect to 0x1002 -> fault_o=1, istb_o=0 until reset_i; without it -> fetch resumes at 0x1000, fault_o=0.
